// File: rtl/cve2_branch_predict_bht.sv
// Dynamic branch predictor for the cve2 fetch stage: RV32/RVC branch and jump decode,
// PC + immediate target, and a PC-indexed table of saturating counters with a flush engine.
module cve2_branch_predict_bht #(
    parameter int unsigned BhtEntries = 64,
    parameter int unsigned CtrWidth   = 2,
    parameter int unsigned CtrInit    = 2**(CtrWidth-1)-1,
    parameter bit          EnableBht  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_valid_i,
    output logic        predict_branch_taken_o,
    output logic [31:0] predict_branch_pc_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic        flush_i,
    output logic        flush_busy_o
);

    localparam int unsigned         IdxW     = $clog2(BhtEntries);
    localparam logic [CtrWidth-1:0] CtrInitV = CtrWidth'(CtrInit);
    localparam logic [CtrWidth-1:0] CtrMax   = {CtrWidth{1'b1}};
    localparam logic [IdxW-1:0]     IdxLast  = IdxW'(BhtEntries - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic logic [CtrWidth-1:0] sat_step(input logic [CtrWidth-1:0] ctr,
                                                     input logic                up);
        logic [CtrWidth-1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != CtrMax) res = ctr + CtrWidth'(1);
        end else begin
            if (ctr != '0) res = ctr - CtrWidth'(1);
        end
        return res;
    endfunction

    logic [CtrWidth-1:0] r_ctr [BhtEntries];
    state_e              r_state;
    state_e              w_state_nxt;
    logic [IdxW-1:0]     r_flush_idx;
    logic [IdxW-1:0]     w_flush_idx_nxt;
    logic                w_flush_we;
    logic                w_busy;

    logic               w_is_b, w_is_j, w_is_cb, w_is_cj;
    logic signed [31:0] w_imm_b, w_imm_j, w_imm_cb, w_imm_cj, w_imm;
    logic [IdxW-1:0]    w_pred_idx;
    logic [CtrWidth-1:0] w_pred_ctr;
    logic               w_dir;

    logic                w_upd_we;
    logic [IdxW-1:0]     w_upd_idx;
    logic [CtrWidth-1:0] w_upd_ctr;
    logic                w_unused_upd_pc;

    // Decode: compressed forms live in the low halfword
    assign w_is_b  = (fetch_rdata_i[6:0] == 7'b1100011);
    assign w_is_j  = (fetch_rdata_i[6:0] == 7'b1101111);
    assign w_is_cb = (fetch_rdata_i[1:0] == 2'b01) && (fetch_rdata_i[15:14] == 2'b11);
    assign w_is_cj = (fetch_rdata_i[1:0] == 2'b01) &&
                     ((fetch_rdata_i[15:13] == 3'b101) || (fetch_rdata_i[15:13] == 3'b001));

    assign w_imm_b  = {{20{fetch_rdata_i[31]}}, fetch_rdata_i[7], fetch_rdata_i[30:25],
                       fetch_rdata_i[11:8], 1'b0};
    assign w_imm_j  = {{12{fetch_rdata_i[31]}}, fetch_rdata_i[19:12], fetch_rdata_i[20],
                       fetch_rdata_i[30:21], 1'b0};
    assign w_imm_cb = {{24{fetch_rdata_i[12]}}, fetch_rdata_i[6:5], fetch_rdata_i[2],
                       fetch_rdata_i[11:10], fetch_rdata_i[4:3], 1'b0};
    assign w_imm_cj = {{21{fetch_rdata_i[12]}}, fetch_rdata_i[8], fetch_rdata_i[10:9],
                       fetch_rdata_i[6], fetch_rdata_i[7], fetch_rdata_i[2],
                       fetch_rdata_i[11], fetch_rdata_i[5:3], 1'b0};

    always_comb begin
        w_imm = w_imm_b;
        if (w_is_j) begin
            w_imm = w_imm_j;
        end else if (w_is_cj) begin
            w_imm = w_imm_cj;
        end else if (w_is_cb) begin
            w_imm = w_imm_cb;
        end
    end

    assign predict_branch_pc_o = fetch_pc_i + $unsigned(w_imm);

    // Direction: no bypass, so a same-cycle update is not visible here
    assign w_busy     = (r_state == FLUSH);
    assign w_pred_idx = fetch_pc_i[IdxW:1];
    assign w_pred_ctr = r_ctr[w_pred_idx];
    assign w_dir      = (EnableBht && !w_busy) ? w_pred_ctr[CtrWidth-1] : w_imm[31];

    assign predict_branch_taken_o = fetch_valid_i &
                                    (w_is_j | w_is_cj | ((w_is_b | w_is_cb) & w_dir));
    assign flush_busy_o = w_busy;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_idx_nxt = r_flush_idx;
        w_flush_we      = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush_i) begin
                    w_state_nxt     = FLUSH;
                    w_flush_idx_nxt = '0;
                end
            end
            FLUSH: begin
                w_flush_we = 1'b1;
                if (flush_i) begin
                    w_flush_idx_nxt = '0;
                end else if (r_flush_idx == IdxLast) begin
                    w_state_nxt     = IDLE;
                    w_flush_idx_nxt = '0;
                end else begin
                    w_flush_idx_nxt = r_flush_idx + IdxW'(1);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_flush_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_flush_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_idx <= w_flush_idx_nxt;
        end
    end

    // Training is dropped while flushing or when a flush is requested the same cycle
    assign w_upd_we        = update_valid_i && (r_state == IDLE) && !flush_i;
    assign w_upd_idx       = update_pc_i[IdxW:1];
    assign w_upd_ctr       = sat_step(r_ctr[w_upd_idx], update_taken_i);
    assign w_unused_upd_pc = ^{update_pc_i[31:IdxW+1], update_pc_i[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BhtEntries; i++) begin
                r_ctr[i] <= CtrInitV;
            end
        end else if (w_flush_we) begin
            r_ctr[r_flush_idx] <= CtrInitV;
        end else if (w_upd_we) begin
            r_ctr[w_upd_idx] <= w_upd_ctr;
        end
    end

`ifndef SYNTHESIS
    int unsigned r_busy_run;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy_run <= 0;
        end else if (flush_i || !w_busy) begin
            r_busy_run <= 0;
        end else begin
            r_busy_run <= r_busy_run + 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && fetch_valid_i) begin
            a_decode_onehot: assert ($onehot0({w_is_b, w_is_j, w_is_cb, w_is_cj}))
                else $error("multiple decode types set");
        end
        if (rst_ni && w_busy && !flush_i) begin
            a_busy_bound: assert (r_busy_run < BhtEntries)
                else $error("flush busy exceeded table size");
        end
    end
`endif

endmodule

// File: tb/tb_cve2_branch_predict_bht.sv
// Directed bench for cve2_branch_predict_bht: dynamic instance plus an EnableBht=0 instance
// sharing the same stimulus; expected values are hand-computed from the instruction encodings.
module tb_cve2_branch_predict_bht;

    localparam logic [31:0] BEQ_P8   = 32'h0000_0463; // beq x0,x0,+8
    localparam logic [31:0] BNE_M8   = 32'hFE00_1CE3; // bne x0,x0,-8
    localparam logic [31:0] CBNEZ_M4 = 32'h0000_FC75; // c.bnez x8,-4
    localparam logic [31:0] JAL_M2K  = 32'h801F_F06F; // jal x0,-2048
    localparam logic [31:0] CJ_P4    = 32'h0000_A011; // c.j +4

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_rdata;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        flush;
    logic        taken, taken_s;
    logic [31:0] tgt, tgt_s;
    logic        busy, busy_s;

    int n_chk = 0;
    int n_err = 0;

    cve2_branch_predict_bht u_dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .fetch_rdata_i          (fetch_rdata),
        .fetch_pc_i             (fetch_pc),
        .fetch_valid_i          (fetch_valid),
        .predict_branch_taken_o (taken),
        .predict_branch_pc_o    (tgt),
        .update_valid_i         (update_valid),
        .update_pc_i            (update_pc),
        .update_taken_i         (update_taken),
        .flush_i                (flush),
        .flush_busy_o           (busy)
    );

    cve2_branch_predict_bht #(.EnableBht(1'b0)) u_dut_static (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .fetch_rdata_i          (fetch_rdata),
        .fetch_pc_i             (fetch_pc),
        .fetch_valid_i          (fetch_valid),
        .predict_branch_taken_o (taken_s),
        .predict_branch_pc_o    (tgt_s),
        .update_valid_i         (update_valid),
        .update_pc_i            (update_pc),
        .update_taken_i         (update_taken),
        .flush_i                (flush),
        .flush_busy_o           (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc, input logic vld);
        fetch_rdata = instr;
        fetch_pc    = pc;
        fetch_valid = vld;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        update_valid = 1'b1;
        update_pc    = pc;
        update_taken = tk;
        step();
        update_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n        = 1'b0;
        fetch_rdata  = '0;
        fetch_pc     = '0;
        fetch_valid  = 1'b0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
        flush        = 1'b0;
        #17;
        rst_n = 1'b1;
        step();

        check_eq("reset_busy", busy, 0);
        check_eq("reset_busy_static", busy_s, 0);

        fetch(BEQ_P8, 32'h100, 1'b1);
        check_eq("beq_init_taken", taken, 0);
        check_eq("beq_init_tgt", tgt, 32'h108);
        check_eq("beq_static_fwd", taken_s, 0);

        // idx0 counter: 1 -> 2 -> 3, then saturate
        upd(32'h100, 1'b1);
        check_eq("ctr_2_taken", taken, 1);
        upd(32'h100, 1'b1);
        check_eq("ctr_3_taken", taken, 1);
        for (int i = 0; i < 4; i++) begin
            upd(32'h100, 1'b1);
            check_eq("ctr_sat_hi", taken, 1);
        end
        upd(32'h100, 1'b0);
        check_eq("ctr_dec_2", taken, 1);
        upd(32'h100, 1'b0);
        check_eq("ctr_dec_1", taken, 0);
        upd(32'h100, 1'b0);
        upd(32'h100, 1'b0);
        check_eq("ctr_sat_lo", taken, 0);
        upd(32'h100, 1'b1);
        check_eq("ctr_lo_inc_1", taken, 0);
        upd(32'h100, 1'b1);
        check_eq("ctr_lo_inc_2", taken, 1);
        check_eq("static_ignores_ctr", taken_s, 0);

        // idx1 (0x202) untouched, idx0 (0x200) trained to 2
        fetch(CBNEZ_M4, 32'h202, 1'b1);
        check_eq("cbnez_202_dyn", taken, 0);
        check_eq("cbnez_202_tgt", tgt, 32'h1FE);
        check_eq("cbnez_202_static", taken_s, 1);
        check_eq("cbnez_202_static_tgt", tgt_s, 32'h1FE);
        fetch(CBNEZ_M4, 32'h200, 1'b1);
        check_eq("cbnez_200_dyn", taken, 1);
        check_eq("cbnez_200_tgt", tgt, 32'h1FC);

        fetch(BNE_M8, 32'h400, 1'b1);
        check_eq("bne_back_static", taken_s, 1);
        check_eq("bne_back_tgt", tgt, 32'h3F8);

        fetch(JAL_M2K, 32'h1000, 1'b1);
        check_eq("jal_taken", taken, 1);
        check_eq("jal_tgt", tgt, 32'h800);
        fetch(JAL_M2K, 32'h1000, 1'b0);
        check_eq("jal_novalid_taken", taken, 0);
        check_eq("jal_novalid_tgt", tgt, 32'h800);

        fetch(CJ_P4, 32'h300, 1'b1);
        check_eq("cj_taken", taken, 1);
        check_eq("cj_tgt", tgt, 32'h304);
        fetch(BEQ_P8, 32'h100, 1'b0);
        check_eq("beq_novalid", taken, 0);

        // Saturate idx0, idx1, idx63 then flush with a colliding update
        upd(32'h100, 1'b1);
        upd(32'h202, 1'b1);
        upd(32'h202, 1'b1);
        upd(32'h07E, 1'b1);
        upd(32'h07E, 1'b1);
        fetch(BEQ_P8, 32'h07E, 1'b1);
        check_eq("idx63_trained", taken, 1);
        fetch(CBNEZ_M4, 32'h202, 1'b1);
        check_eq("idx1_trained", taken, 1);

        flush        = 1'b1;
        update_valid = 1'b1;
        update_pc    = 32'h100;
        update_taken = 1'b1;
        step();
        flush        = 1'b0;
        update_valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 5) check_eq("flush_static_dir", taken, 1);
            if (cnt == 10) begin
                update_valid = 1'b1;
                update_pc    = 32'h100;
                update_taken = 1'b1;
            end else begin
                update_valid = 1'b0;
            end
            step();
        end
        update_valid = 1'b0;
        check_eq("flush_busy_len", cnt, 64);
        for (int i = 0; i < 64; i++) begin
            fetch(BEQ_P8, 32'(i * 2), 1'b1);
            check_eq("post_flush_nt", taken, 0);
        end

        // Restart flush at busy cycle 30
        flush = 1'b1;
        step();
        flush = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            cnt++;
            flush = (cnt == 30);
            step();
        end
        flush = 1'b0;
        check_eq("flush_restart_len", cnt, 94);

        // Asynchronous reset in the middle of a flush
        upd(32'h050, 1'b1);
        upd(32'h050, 1'b1);
        fetch(BEQ_P8, 32'h050, 1'b1);
        check_eq("idx40_trained", taken, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("mid_flush_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_idx40", taken, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("post_rst_busy", busy, 0);
        fetch(BEQ_P8, 32'h050, 1'b1);
        check_eq("post_rst_idx40", taken, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cve2_branch_predict_bht.md
Name: cve2_branch_predict_bht

Overview:
- Dynamic branch predictor for the cve2 fetch stage; successor to the static backward-taken predictor.
- Decodes fetched RV32 and RVC branches and jumps, then computes the target as PC + sign-extended immediate.
- Jumps (JAL, C.J, C.JAL) are always predicted taken.
- Conditional branches (BRANCH, C.BEQZ, C.BNEZ) are predicted from a PC-indexed table of saturating counters, trained from resolved branch outcomes.
- A sequential flush engine re-initialises the table. While the flush runs, prediction falls back to the static rule: taken if the offset is negative.

Parameters:
- BhtEntries, 64, number of counters; power of two, range 2..1024. IdxW = log2(BhtEntries).
- CtrWidth, 2, counter width in bits; range 1..4.
- CtrInit, 2**(CtrWidth-1)-1, counter value after reset and flush. The default is weakly not-taken.
- EnableBht, 1, when 0 conditional branches always use the static rule; the table and flush engine are still present.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- fetch_rdata_i  in  32  fetched instruction; a compressed instruction sits in bits [15:0]
- fetch_pc_i  in  32  PC of the fetched instruction
- fetch_valid_i  in  1  fetch_rdata_i and fetch_pc_i are valid
- predict_branch_taken_o  out  1  prediction is taken
- predict_branch_pc_o  out  32  predicted target
- update_valid_i  in  1  a conditional branch resolved this cycle
- update_pc_i  in  32  PC of the resolved branch
- update_taken_i  in  1  resolved direction
- flush_i  in  1  single-cycle request to re-initialise the table
- flush_busy_o  out  1  flush in progress

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - all counters = CtrInit
  - FSM = IDLE, flush_busy_o = 0, flush index = 0
  - predict outputs are combinational and remain a function of the inputs and the table.
- Decode:
  - instr_b: opcode 1100011. instr_j: opcode 1101111.
  - instr_cb: [1:0]=01 and [15:13] is 110 or 111. instr_cj: [1:0]=01 and [15:13] is 101 or 001.
  - Immediates are the standard B, J, CB and CJ encodings, sign-extended to 32 bits.
  - When none of the four types matches, the B immediate is selected.
- Target: predict_branch_pc_o = fetch_pc_i + imm, modulo 2^32. Valid regardless of fetch_valid_i.
- Prediction index: idx = fetch_pc_i[IdxW:1]. PC bit 0 is ignored; bit 1 is included so that compressed branches are distinguished.
- Conditional branch direction:
  - Uses the dynamic rule, ctr[idx][CtrWidth-1], when EnableBht=1 and flush_busy_o=0.
  - Otherwise uses the static rule: imm[31].
- predict_branch_taken_o = fetch_valid_i & (instr_j | instr_cj | ((instr_b | instr_cb) & dir)). It is purely combinational, with zero latency.
- Training:
  - When update_valid_i=1 and FSM=IDLE, at the clock edge, entry update_pc_i[IdxW:1] changes:
    - saturating +1 if update_taken_i = 1
    - saturating -1 otherwise
  - Saturation bounds are 0 and 2**CtrWidth-1.
  - No bypass: a prediction to the same index in the same cycle sees the pre-update value.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH when flush_i=1; flush index := 0.
  - In FLUSH: flush_busy_o=1; each cycle writes ctr[index] := CtrInit and increments index.
  - After writing BhtEntries-1, return to IDLE.
  - Timing: flush_i sampled at edge t gives flush_busy_o=1 for exactly BhtEntries cycles. The first clean entry is visible one cycle after that edge.
  - flush_i while in FLUSH restarts the flush: index := 0, and busy is extended.
  - update_valid_i during FLUSH, or in the same cycle as flush_i, is dropped. No queueing.
- Index wrap: the flush index counter is IdxW bits wide. Terminal detection is index == BhtEntries-1 and must not rely on overflow.
- Asynchronous reset mid-flush: returns to IDLE with the whole table at CtrInit.
- Simulation assertions:
  - at most one of the four decode types is set while fetch_valid_i=1
  - flush_busy_o is never high for more than BhtEntries consecutive cycles without flush_i

Test Plan:
- Reset, then a BEQ at PC 0x100 with offset +8 and fetch_valid_i=1 -> taken=0, target 0x108. Counter 01 gives not-taken.
- Two updates to PC 0x100 with taken=1, then a forward BEQ -> taken=1. Four further taken updates keep the counter at 11. Four not-taken updates bring it to 00 and prediction to 0.
- Backward C.BNEZ at PC 0x202 with offset -4, both during flush and with EnableBht=0 -> taken=1, target 0x1FE. Index 0x202 is separate from index 0x200.
- JAL with imm=-2048 at PC 0x1000 -> taken=1, target 0x800. The same with fetch_valid_i=0 -> taken=0, target still 0x800.
- Set counters to 11, pulse flush_i, and apply update_valid_i on the same cycle -> busy=1 for exactly 64 cycles and the update is lost. After the flush, all entries predict not-taken.
- Pulse flush_i again at busy cycle 30 -> busy lasts 64 cycles from the restart. Assert rst_ni mid-flush -> busy drops asynchronously and the table reads CtrInit.
